// File: rtl/agc_loop_ctrl_if.sv
// Update/response channel between the AGC loop controller and the error/integrator datapath.
interface agc_loop_ctrl_if #(
  parameter int AWIDTH   = 30,
  parameter int BWIDTH   = 18,
  parameter int DWIDTH   = 27,
  parameter int OUTWIDTH = 48
);
  logic                       err_valid;
  logic signed [BWIDTH-1:0]   err_coeff;
  logic signed [AWIDTH-1:0]   err_data;
  logic signed [DWIDTH-1:0]   err_r_level;
  logic                       err_valid_in;
  logic signed [OUTWIDTH-1:0] err_accum;

  modport master (
    output err_valid, err_coeff, err_data, err_r_level,
    input  err_valid_in, err_accum
  );

  modport slave (
    input  err_valid, err_coeff, err_data, err_r_level,
    output err_valid_in, err_accum
  );
endinterface

// File: rtl/agc_loop_ctrl.sv
// AGC loop sequencer: block-averages power samples, issues one datapath update per block,
// runs the acquire/track lock FSM and turns the integrator response into a saturated gain.
module agc_loop_ctrl #(
  parameter int                 AWIDTH       = 30,
  parameter int                 BWIDTH       = 18,
  parameter int                 DWIDTH       = 27,
  parameter int                 OUTWIDTH     = 48,
  parameter int                 GWIDTH       = 16,
  parameter int                 AVG_LOG2     = 4,
  parameter int                 GAIN_SHIFT   = 24,
  parameter int                 LOCK_CNT     = 8,
  parameter int                 RESP_TIMEOUT = 15,
  parameter logic [GWIDTH-1:0]  GAIN_INIT    = 16'h4000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     freeze,
  input  logic                     sample_valid,
  input  logic signed [AWIDTH-1:0] sample_power,
  input  logic signed [DWIDTH-1:0] r_level,
  input  logic signed [BWIDTH-1:0] acq_coeff,
  input  logic signed [BWIDTH-1:0] trk_coeff,
  input  logic [DWIDTH-1:0]        lock_thresh,
  input  logic [DWIDTH-1:0]        unlock_thresh,
  agc_loop_ctrl_if.master          err,
  output logic [GWIDTH-1:0]        gain,
  output logic                     gain_valid,
  output logic                     locked,
  output logic [1:0]               state,
  output logic                     timeout_err,
  output logic                     overrun_err
);

  localparam int SUM_W = AWIDTH + AVG_LOG2;
  localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);
  localparam int LK_W  = $clog2(LOCK_CNT + 1);
  localparam logic signed [SUM_W-1:0]    MEAN_MAX = {{(SUM_W-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]    MEAN_MIN = {{(SUM_W-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
  localparam logic signed [OUTWIDTH-1:0] GMAX     = {{(OUTWIDTH-GWIDTH){1'b0}}, {GWIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2, HOLD = 2'd3} state_t;

  function automatic logic signed [DWIDTH-1:0] sat_mean(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] m;
    m = s >>> AVG_LOG2;
    if (m > MEAN_MAX)      return MEAN_MAX[DWIDTH-1:0];
    else if (m < MEAN_MIN) return MEAN_MIN[DWIDTH-1:0];
    else                   return m[DWIDTH-1:0];
  endfunction

  function automatic logic [GWIDTH-1:0] sat_gain(input logic signed [OUTWIDTH-1:0] a);
    logic signed [OUTWIDTH-1:0] g;
    g = a >>> GAIN_SHIFT;
    if (g[OUTWIDTH-1]) return '0;
    else if (g > GMAX) return '1;
    else               return g[GWIDTH-1:0];
  endfunction

  function automatic logic [DWIDTH:0] abs_err(input logic signed [DWIDTH-1:0] r,
                                              input logic signed [DWIDTH-1:0] m);
    logic signed [DWIDTH:0] d;
    d = {r[DWIDTH-1], r} - {m[DWIDTH-1], m};
    return d[DWIDTH] ? -d : d;
  endfunction

  state_t                    state_q, state_d, mode_q, mode_d;
  logic [AVG_LOG2-1:0]       cnt_q;
  logic signed [SUM_W-1:0]   sum_q, sum_nxt;
  logic                      pending_q;
  logic [TMR_W-1:0]          tmr_q;
  logic [LK_W-1:0]           lk_q;
  logic                      err_valid_q, gain_valid_q, timeout_q, overrun_q;
  logic signed [BWIDTH-1:0]  coeff_q;
  logic signed [AWIDTH-1:0]  data_q;
  logic signed [DWIDTH-1:0]  rlev_q;
  logic [GWIDTH-1:0]         gain_q;
  logic signed [DWIDTH-1:0]  mean;
  logic [DWIDTH:0]           e_abs;
  logic running, blk_done, issue, drop, lock_hit, lock_switch, resp;

  assign sum_nxt     = sum_q + {{AVG_LOG2{sample_power[AWIDTH-1]}}, sample_power};
  assign mean        = sat_mean(sum_nxt);
  assign e_abs       = abs_err(r_level, mean);
  assign running     = (state_q == ACQUIRE) || (state_q == TRACK);
  assign blk_done    = sample_valid && (state_q != IDLE) && (cnt_q == '1);
  assign issue       = blk_done && running && enable && !freeze && !pending_q;
  assign drop        = blk_done && running && enable && !freeze && pending_q;
  assign lock_hit    = (state_q == ACQUIRE) ? (e_abs < {1'b0, lock_thresh})
                                            : (e_abs > {1'b0, unlock_thresh});
  assign lock_switch = issue && lock_hit && (lk_q == LK_W'(LOCK_CNT - 1));
  assign resp        = enable && pending_q && err.err_valid_in;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:           state_d = ACQUIRE;
        ACQUIRE, TRACK: begin
          if (freeze) begin
            state_d = HOLD;
            mode_d  = state_q;
          end else if (lock_switch) begin
            state_d = (state_q == ACQUIRE) ? TRACK : ACQUIRE;
          end
        end
        HOLD:           if (!freeze) state_d = mode_q;
        default:        state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= ACQUIRE;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid_q  <= 1'b0;
      gain_valid_q <= 1'b0;
      coeff_q      <= '0;
      data_q       <= '0;
      rlev_q       <= '0;
      gain_q       <= GAIN_INIT;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      sum_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      tmr_q        <= '0;
      lk_q         <= '0;
    end else begin
      err_valid_q  <= issue;
      gain_valid_q <= resp;
      // Coefficient follows the mode before any lock transition taken on this block.
      if (issue) begin
        coeff_q <= (state_q == ACQUIRE) ? acq_coeff : trk_coeff;
        data_q  <= {{(AWIDTH-DWIDTH){mean[DWIDTH-1]}}, mean};
        rlev_q  <= r_level;
      end
      if (resp) gain_q <= sat_gain(err.err_accum);
      if (drop) overrun_q <= 1'b1;

      if (!enable || (state_q == IDLE) || ((state_q == HOLD) && !freeze)) begin
        sum_q <= '0;
        cnt_q <= '0;
      end else if (sample_valid) begin
        cnt_q <= cnt_q + 1'b1;
        sum_q <= (cnt_q == '1) ? '0 : sum_nxt;
      end

      if (!enable) begin
        pending_q <= 1'b0;
        tmr_q     <= '0;
      end else if (issue) begin
        pending_q <= 1'b1;
        tmr_q     <= '0;
      end else if (pending_q) begin
        if (err.err_valid_in) begin
          pending_q <= 1'b0;
        end else if (tmr_q == TMR_W'(RESP_TIMEOUT - 1)) begin
          pending_q <= 1'b0;
          timeout_q <= 1'b1;
        end else begin
          tmr_q <= tmr_q + 1'b1;
        end
      end

      if (!enable) begin
        lk_q <= '0;
      end else if (issue) begin
        if (!lock_hit || lock_switch) lk_q <= '0;
        else                          lk_q <= lk_q + 1'b1;
      end
    end
  end

  assign err.err_valid   = err_valid_q;
  assign err.err_coeff   = coeff_q;
  assign err.err_data    = data_q;
  assign err.err_r_level = rlev_q;
  assign gain            = gain_q;
  assign gain_valid      = gain_valid_q;
  assign locked          = (state_q == TRACK);
  assign state           = state_q;
  assign timeout_err     = timeout_q;
  assign overrun_err     = overrun_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Directed bench for agc_loop_ctrl with a fixed-latency datapath responder.
module tb_agc_loop_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, enable, freeze, sample_valid;
  logic signed [29:0] sample_power;
  logic signed [26:0] r_level;
  logic signed [17:0] acq_coeff, trk_coeff;
  logic [26:0]        lock_thresh, unlock_thresh;
  logic [15:0]        gain;
  logic               gain_valid, locked, timeout_err, overrun_err;
  logic [1:0]         state;

  int checks   = 0;
  int failures = 0;
  int dp_lat   = 3;
  logic [47:0] dp_accum = 48'h001234000000;

  agc_loop_ctrl_if #(.AWIDTH(30), .BWIDTH(18), .DWIDTH(27), .OUTWIDTH(48)) dif ();

  agc_loop_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .freeze(freeze),
    .sample_valid(sample_valid), .sample_power(sample_power), .r_level(r_level),
    .acq_coeff(acq_coeff), .trk_coeff(trk_coeff),
    .lock_thresh(lock_thresh), .unlock_thresh(unlock_thresh),
    .err(dif), .gain(gain), .gain_valid(gain_valid), .locked(locked),
    .state(state), .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  // Datapath stand-in: answers dp_lat cycles after each err_valid (0 = never answers).
  initial begin
    dif.err_valid_in = 1'b0;
    dif.err_accum    = '0;
    forever begin
      @(posedge clk); #1;
      if (dif.err_valid === 1'b1 && dp_lat > 0) begin
        repeat (dp_lat) @(posedge clk);
        #1;
        dif.err_accum    = dp_accum;
        dif.err_valid_in = 1'b1;
        @(posedge clk); #1;
        dif.err_valid_in = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic feed(input logic signed [29:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_power = v;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (gain !== 16'h4000) begin failures++; $display("FAIL reset_gain got=%h exp=4000", gain); end
    checks++; if ({dif.err_valid, gain_valid, locked, timeout_err, overrun_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {dif.err_valid, gain_valid, locked, timeout_err, overrun_err});
    end
    checks++; if ({dif.err_coeff, dif.err_data, dif.err_r_level} !== '0) begin
      failures++; $display("FAIL reset_err_bus coeff=%0d data=%0d rlev=%0d exp=0", dif.err_coeff, dif.err_data, dif.err_r_level);
    end
  endtask

  task automatic test_first_block();
    r_level = 27'sd1200; acq_coeff = 18'sd2; trk_coeff = 18'sd7;
    lock_thresh = 27'd10; unlock_thresh = 27'd100;
    enable = 1'b1;
    tick(1);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL enter_acquire got=%0d exp=1", state); end
    feed(30'sd1000, 15);
    checks++; if (dif.err_valid !== 1'b0) begin failures++; $display("FAIL early_issue got=%b exp=0", dif.err_valid); end
    feed(30'sd1000, 1);
    checks++; if (dif.err_valid !== 1'b1) begin failures++; $display("FAIL first_issue got=%b exp=1", dif.err_valid); end
    checks++; if (dif.err_data !== 30'sd1000) begin failures++; $display("FAIL first_data got=%0d exp=1000", dif.err_data); end
    checks++; if (dif.err_coeff !== 18'sd2) begin failures++; $display("FAIL first_coeff got=%0d exp=2", dif.err_coeff); end
    checks++; if (dif.err_r_level !== 27'sd1200) begin failures++; $display("FAIL first_rlev got=%0d exp=1200", dif.err_r_level); end
    tick(1);
    checks++; if (dif.err_valid !== 1'b0) begin failures++; $display("FAIL issue_one_cycle got=%b exp=0", dif.err_valid); end
    tick(2);
    checks++; if (gain_valid !== 1'b0) begin failures++; $display("FAIL gain_valid_early got=%b exp=0", gain_valid); end
    tick(1);
    checks++; if (gain_valid !== 1'b1) begin failures++; $display("FAIL gain_valid_at_4 got=%b exp=1", gain_valid); end
    checks++; if (gain !== 16'h1234) begin failures++; $display("FAIL first_gain got=%h exp=1234", gain); end
    tick(1);
    checks++; if (gain_valid !== 1'b0) begin failures++; $display("FAIL gain_valid_pulse got=%b exp=0", gain_valid); end
    checks++; if (dif.err_data !== 30'sd1000) begin failures++; $display("FAIL data_hold got=%0d exp=1000", dif.err_data); end
  endtask

  task automatic test_lock();
    for (int b = 1; b <= 8; b++) begin
      feed(30'sd1200, 16);
      checks++;
      if (state !== ((b == 8) ? 2'd2 : 2'd1)) begin
        failures++; $display("FAIL lock_state blk=%0d got=%0d exp=%0d", b, state, (b == 8) ? 2 : 1);
      end
    end
    checks++; if (dif.err_coeff !== 18'sd2) begin failures++; $display("FAIL lock_blk_coeff got=%0d exp=2", dif.err_coeff); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL locked_rise got=%b exp=1", locked); end
    feed(30'sd1200, 16);
    checks++; if (dif.err_coeff !== 18'sd7) begin failures++; $display("FAIL track_coeff got=%0d exp=7", dif.err_coeff); end
  endtask

  task automatic test_unlock();
    for (int b = 1; b <= 8; b++) begin
      feed(30'sd1700, 16);
      checks++;
      if (state !== ((b == 8) ? 2'd1 : 2'd2)) begin
        failures++; $display("FAIL unlock_state blk=%0d got=%0d exp=%0d", b, state, (b == 8) ? 1 : 2);
      end
    end
    checks++; if (dif.err_coeff !== 18'sd7) begin failures++; $display("FAIL unlock_blk_coeff got=%0d exp=7", dif.err_coeff); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL locked_fall got=%b exp=0", locked); end
  endtask

  task automatic test_timeout();
    tick(5);
    dp_lat = 0;
    dp_accum = 48'h000055000000;
    feed(30'sd1700, 16);
    checks++; if (dif.err_valid !== 1'b1) begin failures++; $display("FAIL to_issue got=%b exp=1", dif.err_valid); end
    tick(14);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", timeout_err); end
    tick(1);
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_at_15 got=%b exp=1", timeout_err); end
    checks++; if (gain !== 16'h1234) begin failures++; $display("FAIL timeout_gain got=%h exp=1234", gain); end
    dp_lat = 3;
    feed(30'sd1700, 16);
    checks++; if (dif.err_valid !== 1'b1) begin failures++; $display("FAIL post_to_issue got=%b exp=1", dif.err_valid); end
    tick(4);
    checks++; if (gain !== 16'h0055 || gain_valid !== 1'b1) begin
      failures++; $display("FAIL post_to_gain got=%h/%b exp=0055/1", gain, gain_valid);
    end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL overrun_flag got=%b exp=0", overrun_err); end
  endtask

  task automatic test_saturation();
    logic [47:0] acc_tab [4];
    logic [15:0] exp_tab [4];
    acc_tab[0] = 48'hFFFFFB000000; exp_tab[0] = 16'h0000;
    acc_tab[1] = 48'h100000000000; exp_tab[1] = 16'hFFFF;
    acc_tab[2] = 48'h000ABCFFFFFF; exp_tab[2] = 16'h0ABC;
    acc_tab[3] = 48'hFFFFFFFFFFFF; exp_tab[3] = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      dp_accum = acc_tab[k];
      feed(30'sd1700, 16);
      tick(4);
      checks++;
      if (gain !== exp_tab[k]) begin
        failures++; $display("FAIL gain_sat idx=%0d got=%h exp=%h", k, gain, exp_tab[k]);
      end
    end
    feed(30'sh1FFFFFFF, 16);
    checks++; if (dif.err_data !== 30'h03FFFFFF) begin failures++; $display("FAIL mean_sat_hi got=%h exp=03ffffff", dif.err_data); end
    feed(30'sh20000000, 16);
    checks++; if (dif.err_data !== 30'h3C000000) begin failures++; $display("FAIL mean_sat_lo got=%h exp=3c000000", dif.err_data); end
  endtask

  task automatic test_freeze();
    logic bad_issue;
    logic saw_gv;
    dp_accum = 48'h000777000000;
    for (int b = 0; b < 8; b++) feed(30'sd1200, 16);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL relock_state got=%0d exp=2", state); end
    feed(30'sd1200, 2);
    freeze = 1'b1;
    bad_issue = 1'b0;
    saw_gv = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sample_valid = 1'b1;
      sample_power = 30'sd1200;
      tick(1);
      if (dif.err_valid !== 1'b0) bad_issue = 1'b1;
      if (i == 1) saw_gv = gain_valid;
    end
    sample_valid = 1'b0;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL hold_state got=%0d exp=3", state); end
    checks++; if (bad_issue !== 1'b0) begin failures++; $display("FAIL hold_issue got=%b exp=0", bad_issue); end
    checks++; if (saw_gv !== 1'b1 || gain !== 16'h0777) begin
      failures++; $display("FAIL hold_resp got=%b/%h exp=1/0777", saw_gv, gain);
    end
    freeze = 1'b0;
    tick(1);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL release_state got=%0d exp=2", state); end
    feed(30'sd1200, 15);
    checks++; if (dif.err_valid !== 1'b0) begin failures++; $display("FAIL release_early got=%b exp=0", dif.err_valid); end
    feed(30'sd1200, 1);
    checks++; if (dif.err_valid !== 1'b1 || dif.err_coeff !== 18'sd7) begin
      failures++; $display("FAIL release_issue got=%b/%0d exp=1/7", dif.err_valid, dif.err_coeff);
    end
  endtask

  task automatic test_disable();
    tick(5);
    enable = 1'b0;
    tick(1);
    checks++; if (state !== 2'd0 || locked !== 1'b0) begin
      failures++; $display("FAIL disable_state got=%0d/%b exp=0/0", state, locked);
    end
    checks++; if (gain !== 16'h0777) begin failures++; $display("FAIL disable_gain got=%h exp=0777", gain); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL sticky_timeout got=%b exp=1", timeout_err); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; freeze = 1'b0; sample_valid = 1'b0; sample_power = '0;
    r_level = '0; acq_coeff = '0; trk_coeff = '0; lock_thresh = '0; unlock_thresh = '0;
    test_reset();
    test_first_block();
    test_lock();
    test_unlock();
    test_timeout();
    test_saturation();
    test_freeze();
    test_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/agc_loop_ctrl.md
Name: agc_loop_ctrl

Overview:
Sequencing controller for the AGC error/integrator datapath (R_level minus data, times coefficient, accumulated into a 48-bit integrator). It averages incoming power samples over fixed blocks and issues one update per block to the datapath. It selects the acquire or track loop coefficient from a lock state machine, waits for the datapath response, and converts the integrator output into a saturated gain word. It sits between the power detector and the error datapath; its gain output drives the variable-gain stage.

Parameters:
AWIDTH, 30, power sample / datapath data width
BWIDTH, 18, loop coefficient width (signed)
DWIDTH, 27, reference level width (signed)
OUTWIDTH, 48, datapath integrator width
GWIDTH, 16, gain output width (unsigned)
AVG_LOG2, 4, log2 of samples per averaging block
GAIN_SHIFT, 24, right shift from integrator to gain
LOCK_CNT, 8, consecutive blocks needed to lock or unlock
RESP_TIMEOUT, 15, max cycles to wait for datapath response
GAIN_INIT, 16'h4000, gain value after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  loop run enable
freeze  in  1  hold gain, issue no updates
sample_valid  in  1  power sample strobe
sample_power  in  AWIDTH  power sample, signed
r_level  in  DWIDTH  target power level
acq_coeff  in  BWIDTH  coefficient used in ACQUIRE
trk_coeff  in  BWIDTH  coefficient used in TRACK
lock_thresh  in  DWIDTH  |error| threshold for lock
unlock_thresh  in  DWIDTH  |error| threshold for unlock
err_valid  out  1  one-cycle update strobe to datapath
err_coeff  out  BWIDTH  coefficient to datapath
err_data  out  AWIDTH  block mean to datapath
err_r_level  out  DWIDTH  reference to datapath
err_valid_in  in  1  datapath response valid
err_accum  in  OUTWIDTH  datapath integrator value
gain  out  GWIDTH  current gain
gain_valid  out  1  one-cycle pulse on each gain update
locked  out  1  high in TRACK
state  out  2  0=IDLE 1=ACQUIRE 2=TRACK 3=HOLD
timeout_err  out  1  sticky: response timeout
overrun_err  out  1  sticky: block completed while waiting

Behaviour:
- One clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, gain=GAIN_INIT. The following are all 0: err_valid, err_coeff, err_data, err_r_level, gain_valid, locked, timeout_err, overrun_err, sample counter, block sum, lock counter.
- Averaging: while state is not IDLE, each sample_valid adds sign-extended sample_power into an (AWIDTH+AVG_LOG2)-bit sum. The counter wraps at 2^AVG_LOG2.
- On the sample that wraps the counter: mean = sum>>>AVG_LOG2 including that sample, saturated to DWIDTH signed range, then sign-extended to AWIDTH. The sum restarts at 0 the next cycle.
- Issue: when a block completes in ACQUIRE/TRACK and no response is pending, err_valid=1 for exactly one cycle, the cycle after the last sample.
  - err_data = mean; err_r_level = r_level.
  - err_coeff = acq_coeff in ACQUIRE, trk_coeff in TRACK.
  - Outputs hold their values until the next issue.
- Pending: set on issue; cleared on err_valid_in or timeout. If a block completes while pending, that block is dropped and overrun_err is set.
- Timeout: if err_valid_in has not arrived RESP_TIMEOUT cycles after issue, set timeout_err, clear pending, leave gain unchanged.
- err_valid_in while not pending is ignored.
- Response handling, on err_valid_in while pending:
  - g = err_accum>>>GAIN_SHIFT; negative gives 0; above 2^GWIDTH-1 gives all-ones.
  - gain=g registered; gain_valid pulses the next cycle.
- Lock metric, per issued block: e = |r_level - mean|, computed at DWIDTH+1 bits.
- Transitions, evaluated at each issue:
  - IDLE->ACQUIRE when enable=1. Any state->IDLE when enable=0; this clears sums, pending, lock counter, and keeps gain.
  - ACQUIRE: if e<lock_thresh, increment lock counter, else clear it. When counter reaches LOCK_CNT, go to TRACK and clear counter. The transition block is issued with acq_coeff.
  - TRACK: if e>unlock_thresh, increment, else clear. At LOCK_CNT, go to ACQUIRE and clear.
  - freeze=1 in ACQUIRE/TRACK goes to HOLD. Remember the prior mode. Averaging continues, no issues occur, and a pending response is still accepted.
  - freeze=0 in HOLD returns to the remembered mode and restarts the block sum and counter.
- Priority when events coincide: rst > enable=0 > freeze > lock transition.
- locked = (state==TRACK). Sticky flags clear only on rst.

Test Plan:
- Reset, enable=1, 16 samples of 1000, r_level=1200, acq_coeff=2, datapath model with 3-cycle latency -> err_valid 1 cycle after 16th sample; err_data=1000, err_coeff=2; gain_valid 4 cycles later.
- Samples equal r_level, lock_thresh=10, 8 blocks -> state 1->2 after 8th issue; 9th issue uses trk_coeff.
- In TRACK, feed mean = r_level+500 with unlock_thresh=100 for 8 blocks -> back to ACQUIRE; locked falls.
- Datapath model never responds -> timeout_err=1 at issue+15; gain unchanged; next block issues normally.
- err_accum = -5<<24 -> gain=0; err_accum = 1<<44 -> gain=16'hFFFF.
- freeze mid-block in TRACK, then release -> no err_valid during HOLD; returns to TRACK; first issue after exactly 16 new samples.
